// File: rtl/game_pkg.sv
// game_pkg: shared game geometry constants.
//   POS_W        - width of the x/y fields carried on pos_if
//   JERRY_WIDTH  - Jerry sprite width in pixels
//   JERRY_HEIGHT - Jerry sprite height in pixels
package game_pkg;
   localparam int unsigned POS_W        = 12;
   localparam int unsigned JERRY_WIDTH  = 32;
   localparam int unsigned JERRY_HEIGHT = 32;
endpackage

// File: rtl/pos_if.sv
// pos_if: screen position bundle (x, y) shared between game blocks.
//   in  modport - consumer view (x, y are inputs)
//   out modport - producer view (x, y are outputs)
interface pos_if;
   import game_pkg::*;
   logic [POS_W-1:0] x;
   logic [POS_W-1:0] y;
   modport in  (input  x, input  y);
   modport out (output x, output y);
endinterface

// File: rtl/cheese_spawn_ctrl.sv
// cheese_spawn_ctrl: draws pseudo-random cheese positions away from Jerry,
// enforces a respawn delay after each pickup and freezes at the cheese goal.
// Ports:
//   clk             - system clock
//   rst             - asynchronous active-low reset
//   reset           - synchronous game restart (level, active-high)
//   game_start      - pulse, starts spawning from IDLE
//   is_cheese_taken - pulse, cheese picked up (honoured only while shown)
//   cheese_gm       - pulse, cheese goal reached (honoured only while shown)
//   jerrypos        - Jerry position, sampled while drawing
//   cheesepos       - registered cheese position
//   cheese_visible  - cheese drawn and collidable
//   spawned         - 1-cycle pulse when a new position is committed
//   busy            - high while drawing or waiting to respawn
module cheese_spawn_ctrl
   import game_pkg::*;
#(
   parameter int unsigned X_MIN         = 32,
   parameter int unsigned X_MAX         = 760,
   parameter int unsigned Y0            = 520,
   parameter int unsigned Y1            = 400,
   parameter int unsigned Y2            = 280,
   parameter int unsigned Y3            = 160,
   parameter int unsigned RESPAWN_DELAY = 65_000_000,
   parameter int unsigned CLEAR_MARGIN  = 16,
   parameter int unsigned MAX_TRIES     = 8,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic clk,
   input  logic rst,
   input  logic reset,
   input  logic game_start,
   input  logic is_cheese_taken,
   input  logic cheese_gm,
   pos_if.in    jerrypos,
   pos_if.out   cheesepos,
   output logic cheese_visible,
   output logic spawned,
   output logic busy
);

   localparam int unsigned DLY_W = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY) : 1;
   localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   localparam logic [10:0]      X_SPAN   = 11'(X_MAX - X_MIN);
   localparam logic [12:0]      CLR_X    = 13'(JERRY_WIDTH + CLEAR_MARGIN);
   localparam logic [12:0]      CLR_Y    = 13'(JERRY_HEIGHT + CLEAR_MARGIN);
   localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(RESPAWN_DELAY - 1);
   localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAW,
      S_SHOWN,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state_q,    state_d;
   logic [15:0]      lfsr_q,     lfsr_d;
   logic [TRY_W-1:0] try_q,      try_d;
   logic [DLY_W-1:0] dly_q,      dly_d;
   logic [POS_W-1:0] cheese_x_q, cheese_x_d;
   logic [POS_W-1:0] cheese_y_q, cheese_y_d;
   logic             visible_q,  visible_d;
   logic             spawned_q,  spawned_d;
   logic             busy_q,     busy_d;

   logic [12:0]      cand_x;
   logic [POS_W-1:0] cand_y;
   logic [12:0]      dx, dy;
   logic [12:0]      dx_abs, dy_abs;
   logic             out_of_range;
   logic             near_jerry;
   logic             cand_ok;

   // Fibonacci LFSR, taps 16/14/13/11; free-running in every state.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // Candidate derived from the current LFSR value. Differences are taken
   // at 13 bits and read as two's complement, so no wrap at these ranges.
   always_comb begin
      cand_x = 13'(X_MIN) + {2'b00, lfsr_q[10:0]};
      cand_y = POS_W'(Y0);
      case (lfsr_q[12:11])
         2'd0:    cand_y = POS_W'(Y0);
         2'd1:    cand_y = POS_W'(Y1);
         2'd2:    cand_y = POS_W'(Y2);
         default: cand_y = POS_W'(Y3);
      endcase
      dx           = {1'b0, jerrypos.x} - cand_x;
      dy           = {1'b0, jerrypos.y} - {1'b0, cand_y};
      dx_abs       = dx[12] ? (~dx + 13'd1) : dx;
      dy_abs       = dy[12] ? (~dy + 13'd1) : dy;
      out_of_range = lfsr_q[10:0] > X_SPAN;
      near_jerry   = (dx_abs < CLR_X) && (dy_abs < CLR_Y);
      cand_ok      = !out_of_range && !near_jerry;
   end

   always_comb begin
      state_d    = state_q;
      try_d      = try_q;
      dly_d      = dly_q;
      cheese_x_d = cheese_x_q;
      cheese_y_d = cheese_y_q;
      spawned_d  = 1'b0;

      if (reset) begin
         state_d    = S_IDLE;
         try_d      = '0;
         dly_d      = '0;
         cheese_x_d = '0;
         cheese_y_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (game_start) begin
                  state_d = S_DRAW;
                  try_d   = '0;
               end
            end
            S_DRAW: begin
               if (cand_ok) begin
                  cheese_x_d = cand_x[POS_W-1:0];
                  cheese_y_d = cand_y;
                  spawned_d  = 1'b1;
                  state_d    = S_SHOWN;
               end else if (try_q == TRY_LAST) begin
                  // Last attempt rejected: commit the fixed fallback spot.
                  cheese_x_d = POS_W'(X_MIN);
                  cheese_y_d = POS_W'(Y0);
                  spawned_d  = 1'b1;
                  state_d    = S_SHOWN;
               end else begin
                  try_d = try_q + 1'b1;
               end
            end
            S_SHOWN: begin
               if (cheese_gm) begin
                  state_d = S_DONE;
               end else if (is_cheese_taken) begin
                  state_d = S_WAIT;
                  dly_d   = DLY_LOAD;
               end
            end
            S_WAIT: begin
               if (dly_q == '0) begin
                  state_d = S_DRAW;
                  try_d   = '0;
               end else begin
                  dly_d = dly_q - 1'b1;
               end
            end
            S_DONE: begin
               state_d = S_DONE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Status outputs are registered copies of the next state.
      visible_d = (state_d == S_SHOWN);
      busy_d    = (state_d == S_DRAW) || (state_d == S_WAIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         lfsr_q     <= LFSR_SEED;
         try_q      <= '0;
         dly_q      <= '0;
         cheese_x_q <= '0;
         cheese_y_q <= '0;
         visible_q  <= 1'b0;
         spawned_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         try_q      <= try_d;
         dly_q      <= dly_d;
         cheese_x_q <= cheese_x_d;
         cheese_y_q <= cheese_y_d;
         visible_q  <= visible_d;
         spawned_q  <= spawned_d;
         busy_q     <= busy_d;
      end
   end

   assign cheesepos.x    = cheese_x_q;
   assign cheesepos.y    = cheese_y_q;
   assign cheese_visible = visible_q;
   assign spawned        = spawned_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_cheese_spawn_ctrl.sv
// tb_cheese_spawn_ctrl: directed bench for cheese_spawn_ctrl. Two instances
// share stimulus: dut_a with the normal x range and dut_b with X_MAX = X_MIN
// (nearly every draw falls back). A behavioural model predicts every output
// of both instances each cycle; literal checks pin the key timing points.
module tb_cheese_spawn_ctrl;
   import game_pkg::*;

   localparam int          XMIN   = 32;
   localparam int          XMAX_A = 760;
   localparam int          XMAX_B = 32;
   localparam int          DELAY  = 4;
   localparam int          TRIES  = 8;
   localparam int          MARGIN = 16;
   localparam logic [15:0] SEED   = 16'hACE1;

   localparam int PH_IDLE  = 0;
   localparam int PH_DRAW  = 1;
   localparam int PH_SHOWN = 2;
   localparam int PH_WAIT  = 3;
   localparam int PH_DONE  = 4;

   typedef struct {
      int          ph;
      int          tries;
      int          cnt;
      logic [15:0] lfsr;
      int          cx;
      int          cy;
      bit          vis;
      bit          spw;
      bit          bsy;
   } mdl_t;

   logic clk        = 1'b0;
   logic rst_n      = 1'b0;
   logic reset      = 1'b0;
   logic game_start = 1'b0;
   logic taken      = 1'b0;
   logic gm         = 1'b0;
   logic vis_a, spw_a, busy_a;
   logic vis_b, spw_b, busy_b;

   pos_if jerry_if ();
   pos_if cheese_a_if ();
   pos_if cheese_b_if ();

   int   vectors     = 0;
   int   miscompares = 0;
   bit   chk_en      = 1'b0;
   mdl_t ma, mb;
   int   ncyc        = 0;
   int   spw_a_cnt   = 0;
   int   spw_b_cnt   = 0;
   int   b_spawn_cyc = 0;

   always #5 clk = ~clk;

   cheese_spawn_ctrl #(
      .X_MIN(XMIN), .X_MAX(XMAX_A), .RESPAWN_DELAY(DELAY),
      .CLEAR_MARGIN(MARGIN), .MAX_TRIES(TRIES), .LFSR_SEED(SEED)
   ) dut_a (
      .clk(clk), .rst(rst_n), .reset(reset), .game_start(game_start),
      .is_cheese_taken(taken), .cheese_gm(gm), .jerrypos(jerry_if),
      .cheesepos(cheese_a_if), .cheese_visible(vis_a), .spawned(spw_a), .busy(busy_a)
   );

   cheese_spawn_ctrl #(
      .X_MIN(XMIN), .X_MAX(XMAX_B), .RESPAWN_DELAY(DELAY),
      .CLEAR_MARGIN(MARGIN), .MAX_TRIES(TRIES), .LFSR_SEED(SEED)
   ) dut_b (
      .clk(clk), .rst(rst_n), .reset(reset), .game_start(game_start),
      .is_cheese_taken(taken), .cheese_gm(gm), .jerrypos(jerry_if),
      .cheesepos(cheese_b_if), .cheese_visible(vis_b), .spawned(spw_b), .busy(busy_b)
   );

   function automatic logic [15:0] lfsr_next(logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic int ylev(int i);
      case (i)
         0:       return 520;
         1:       return 400;
         2:       return 280;
         default: return 160;
      endcase
   endfunction

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.ph = PH_IDLE; m.tries = 0; m.cnt = 0; m.lfsr = SEED;
      m.cx = 0; m.cy = 0; m.vis = 0; m.spw = 0; m.bsy = 0;
      return m;
   endfunction

   // One clock of game behaviour: returns the registered outputs after the edge.
   function automatic mdl_t mdl_step(mdl_t m, int xmax, bit rs, bit gs, bit tk, bit g,
                                     int jx, int jy);
      mdl_t n = m;
      int   off, cx, cy;
      bit   fits, clash;
      off   = int'(m.lfsr[10:0]);
      cx    = XMIN + off;
      cy    = ylev(int'(m.lfsr[12:11]));
      fits  = (off <= xmax - XMIN);
      clash = (iabs(jx - cx) < int'(JERRY_WIDTH) + MARGIN) &&
              (iabs(jy - cy) < int'(JERRY_HEIGHT) + MARGIN);
      n.lfsr = lfsr_next(m.lfsr);
      n.spw  = 0;
      if (rs) begin
         n.ph = PH_IDLE; n.tries = 0; n.cnt = 0; n.cx = 0; n.cy = 0;
      end else begin
         case (m.ph)
            PH_IDLE:  if (gs) begin n.ph = PH_DRAW; n.tries = 0; end
            PH_DRAW: begin
               if (fits && !clash) begin
                  n.cx = cx; n.cy = cy; n.spw = 1; n.ph = PH_SHOWN;
               end else if (m.tries + 1 >= TRIES) begin
                  n.cx = XMIN; n.cy = ylev(0); n.spw = 1; n.ph = PH_SHOWN;
               end else begin
                  n.tries = m.tries + 1;
               end
            end
            PH_SHOWN: begin
               if (g) n.ph = PH_DONE;
               else if (tk) begin n.ph = PH_WAIT; n.cnt = DELAY - 1; end
            end
            PH_WAIT: begin
               if (m.cnt == 0) begin n.ph = PH_DRAW; n.tries = 0; end
               else n.cnt = m.cnt - 1;
            end
            default: ;
         endcase
      end
      n.vis = (n.ph == PH_SHOWN);
      n.bsy = (n.ph == PH_DRAW) || (n.ph == PH_WAIT);
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma = mdl_reset();
         mb = mdl_reset();
      end else begin
         ma = mdl_step(ma, XMAX_A, reset, game_start, taken, gm,
                       int'(jerry_if.x), int'(jerry_if.y));
         mb = mdl_step(mb, XMAX_B, reset, game_start, taken, gm,
                       int'(jerry_if.x), int'(jerry_if.y));
      end
   end

   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("a_visible", vis_a, ma.vis);
         cmp("a_spawned", spw_a, ma.spw);
         cmp("a_busy", busy_a, ma.bsy);
         cmp("a_x", cheese_a_if.x, ma.cx);
         cmp("a_y", cheese_a_if.y, ma.cy);
         cmp("b_visible", vis_b, mb.vis);
         cmp("b_spawned", spw_b, mb.spw);
         cmp("b_busy", busy_b, mb.bsy);
         cmp("b_x", cheese_b_if.x, mb.cx);
         cmp("b_y", cheese_b_if.y, mb.cy);
      end
   end

   task automatic tick();
      @(negedge clk);
      ncyc++;
      if (spw_a === 1'b1) spw_a_cnt++;
      if (spw_b === 1'b1) begin
         spw_b_cnt++;
         b_spawn_cyc = ncyc;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat, n0cyc, c0, jx, jy, ax, ay;
      logic [15:0] nl;
      bit          lucky, found, ok;

      jerry_if.x = '0;
      jerry_if.y = '0;
      repeat (3) tick();
      chk_en = 1'b1;

      // Reset state
      cmp("rst_visible", vis_a, 0);
      cmp("rst_spawned", spw_a, 0);
      cmp("rst_busy", busy_a, 0);
      cmp("rst_x", cheese_a_if.x, 0);
      cmp("rst_y", cheese_a_if.y, 0);
      rst_n = 1'b1;
      repeat (6) tick();

      // Start: first spawn, plus dut_b fallback after exactly 8 attempts
      nl = ma.lfsr;
      lucky = 0;
      for (int k = 1; k <= TRIES; k++) begin
         nl = lfsr_next(nl);
         if (nl[10:0] == 11'd0) lucky = 1;
      end
      n0cyc = ncyc;
      c0 = spw_b_cnt;
      game_start = 1'b1; tick(); game_start = 1'b0;
      lat = 1;
      while (spw_a !== 1'b1 && lat < 12) begin tick(); lat++; end
      cmp("start_spawn_seen", spw_a, 1);
      cmp("start_latency_in_2_9", (lat >= 2 && lat <= 9), 1);
      ax = int'(cheese_a_if.x);
      ay = int'(cheese_a_if.y);
      cmp("start_x_in_range", (ax >= 32 && ax <= 760), 1);
      cmp("start_y_level", (ay == 520 || ay == 400 || ay == 280 || ay == 160), 1);
      cmp("start_visible_with_spawn", vis_a, 1);
      while (lat < 12) begin tick(); lat++; end
      cmp("fallback_single_spawn", spw_b_cnt - c0, 1);
      cmp("fallback_x", cheese_b_if.x, 32);
      cmp("fallback_visible", vis_b, 1);
      if (!lucky) begin
         cmp("fallback_after_8_tries", b_spawn_cyc - n0cyc, 9);
         cmp("fallback_y", cheese_b_if.y, 520);
      end

      // Pickup, a second (ignored) pickup during WAIT, respawn delay
      taken = 1'b1; tick(); taken = 1'b0;
      cmp("taken_hides_cheese", vis_a, 0);
      cmp("taken_busy_wait", busy_a, 1);
      tick();
      taken = 1'b1; tick(); taken = 1'b0;
      lat = 3;
      while (spw_a !== 1'b1 && lat < 20) begin tick(); lat++; end
      cmp("respawn_seen", spw_a, 1);
      cmp("respawn_latency_in_6_13", (lat >= 6 && lat <= 13), 1);
      repeat (12) tick();

      // game_start while SHOWN is ignored
      game_start = 1'b1; tick(); game_start = 1'b0;
      cmp("start_in_shown_visible", vis_a, 1);
      cmp("start_in_shown_no_spawn", spw_a, 0);
      cmp("start_in_shown_not_busy", busy_a, 0);

      // Goal beats pickup in the same cycle
      gm = 1'b1; taken = 1'b1; tick(); gm = 1'b0; taken = 1'b0;
      cmp("goal_hides_cheese", vis_a, 0);
      cmp("goal_not_wait", busy_a, 0);
      c0 = spw_a_cnt;
      repeat (1000) tick();
      cmp("done_no_spawn_1000", spw_a_cnt - c0, 0);
      taken = 1'b1; game_start = 1'b1; tick(); taken = 1'b0; game_start = 1'b0;
      tick();
      cmp("done_ignores_inputs", busy_a, 0);

      // Synchronous restart
      reset = 1'b1; tick(); reset = 1'b0;
      cmp("restart_x_cleared", cheese_a_if.x, 0);
      cmp("restart_y_cleared", cheese_a_if.y, 0);
      cmp("restart_not_busy", busy_a, 0);

      // Pickup in IDLE is ignored; game_start with reset stays in IDLE
      taken = 1'b1; tick(); taken = 1'b0; tick();
      cmp("idle_ignores_taken", busy_a, 0);
      game_start = 1'b1; reset = 1'b1; tick(); game_start = 1'b0; reset = 1'b0;
      cmp("start_with_reset_idle", busy_a, 0);
      tick();
      cmp("start_with_reset_idle_2", busy_a, 0);

      // Jerry exclusion: park Jerry on the first candidate of the next draw
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         nl = lfsr_next(ma.lfsr);
         if (int'(nl[10:0]) <= XMAX_A - XMIN) found = 1;
         else tick();
      end
      cmp("excl_setup_found", found, 1);
      jx = XMIN + int'(nl[10:0]);
      jy = ylev(int'(nl[12:11]));
      jerry_if.x = 12'(jx);
      jerry_if.y = 12'(jy);
      game_start = 1'b1; tick(); game_start = 1'b0; tick();
      cmp("excl_first_candidate_rejected", spw_a, 0);
      lat = 2;
      while (spw_a !== 1'b1 && lat < 12) begin tick(); lat++; end
      cmp("excl_spawn_seen", spw_a, 1);
      ax = int'(cheese_a_if.x);
      ay = int'(cheese_a_if.y);
      ok = (iabs(ax - jx) >= 48) || (iabs(ay - jy) >= 48) || (ax == 32 && ay == 520);
      cmp("excl_clear_of_jerry", ok, 1);
      repeat (10) tick();

      // Asynchronous reset in the middle of WAIT
      taken = 1'b1; tick(); taken = 1'b0; tick();
      cmp("wait_before_rst", busy_a, 1);
      #2 rst_n = 1'b0;
      #1;
      cmp("async_rst_visible", vis_a, 0);
      cmp("async_rst_spawned", spw_a, 0);
      cmp("async_rst_busy", busy_a, 0);
      cmp("async_rst_x", cheese_a_if.x, 0);
      cmp("async_rst_y", cheese_a_if.y, 0);
      tick();
      rst_n = 1'b1;
      tick();
      cmp("after_rst_idle_busy", busy_a, 0);
      cmp("after_rst_idle_visible", vis_a, 0);
      game_start = 1'b1; tick(); game_start = 1'b0;
      lat = 1;
      while (spw_a !== 1'b1 && lat < 12) begin tick(); lat++; end
      cmp("after_rst_spawn_seen", spw_a, 1);
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cheese_spawn_ctrl.md
# cheese_spawn_ctrl

Sequences cheese placement for the game. It draws pseudo-random cheese positions, publishes them on a `pos_if` and keeps cheese off Jerry's current location. It also enforces a respawn delay after each pickup and freezes once the cheese goal is reached. It sits between the game-state logic and the cheese collision/counter block: it consumes the taken/goal pulses and drives the position that block checks against.

## Interface
Parameters:
- `X_MIN`, default 32: leftmost legal cheese x.
- `X_MAX`, default 760: rightmost legal cheese x; requires `X_MAX - X_MIN < 2048`.
- `Y0`, `Y1`, `Y2`, `Y3`, defaults 520/400/280/160: the four legal cheese y levels (platform tops).
- `RESPAWN_DELAY`, default 65_000_000: cycles between pickup and next draw; requires ≥ 1.
- `CLEAR_MARGIN`, default 16: extra clearance around Jerry, in pixels.
- `MAX_TRIES`, default 8: draw attempts before fallback.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `reset` in 1: synchronous game restart, active-high, level.
- `game_start` in 1: pulse that starts cheese spawning.
- `is_cheese_taken` in 1: 1-cycle pulse, Jerry picked the cheese.
- `cheese_gm` in 1: 1-cycle pulse, cheese goal reached.
- `jerrypos` `pos_if.in`: Jerry x/y.
- `cheesepos` `pos_if.out`: current cheese x/y, registered.
- `cheese_visible` out 1: cheese is drawn and collidable.
- `spawned` out 1: 1-cycle pulse when a new position is committed.
- `busy` out 1: high in DRAW and WAIT.

## Operation
- LFSR: 16 bit, Fibonacci, taps 16/14/13/11. It shifts every cycle in every state and is reset only by `rst`.
- States: IDLE, DRAW, SHOWN, WAIT, DONE.
- IDLE: outputs are low and `cheesepos` = (0,0). `game_start` → DRAW, with the try counter cleared.
- DRAW handles one attempt per cycle:
  - Candidate x = `X_MIN + lfsr[10:0]`.
  - Candidate y = `Y[lfsr[12:11]]`, i.e. Y0..Y3 selected by `lfsr[12:11]`.
  - The candidate is rejected if `lfsr[10:0] > X_MAX - X_MIN`.
  - The candidate is also rejected if both of these hold: `|jx - cx| < JERRY_WIDTH + CLEAR_MARGIN` and `|jy - cy| < JERRY_HEIGHT + CLEAR_MARGIN`. `JERRY_WIDTH` and `JERRY_HEIGHT` come from `game_pkg`.
  - Absolute differences are computed at 13-bit signed width; there is no wrap.
  - Accept → register the candidate into `cheesepos`, assert `spawned`, go to SHOWN.
  - Reject → increment the try counter.
  - On the `MAX_TRIES`-th rejection, commit the fallback (`X_MIN`, `Y0`) unconditionally and go to SHOWN.
- SHOWN: `cheese_visible` = 1.
  - `cheese_gm` → DONE. This has priority over `is_cheese_taken` in the same cycle.
  - `is_cheese_taken` → WAIT, with the delay counter loaded to `RESPAWN_DELAY - 1`.
- WAIT: `cheese_visible` = 0 and `cheesepos` holds its last value. The delay counter decrements each cycle; at 0 → DRAW, with the try counter cleared.
- DONE: `cheese_visible` = 0. The block stays here until `reset`.
- `reset` high in any state → IDLE next cycle. All counters clear and `cheesepos` goes to (0,0). `reset` has priority over every other input.
- `is_cheese_taken` and `cheese_gm` are ignored outside SHOWN.
- `game_start` is ignored outside IDLE.
- If `game_start` and `reset` are high in the same cycle, the block stays in IDLE.

## Timing
- All outputs are registered.
- On `rst` low: state IDLE, all outputs 0, `cheesepos` = (0,0), LFSR = `LFSR_SEED`, counters 0. The reset is asynchronous and takes effect mid-operation from any state.
- `game_start` at cycle t → DRAW at t+1. The earliest `spawned`/`cheese_visible` is at t+2.
- A draw takes 1..`MAX_TRIES` cycles. `spawned` is coincident with the first cycle that `cheese_visible` = 1 and the new `cheesepos` is valid.
- `is_cheese_taken` at t → `cheese_visible` = 0 at t+1. DRAW is entered at t+1+`RESPAWN_DELAY`.
- `cheese_gm` at t → DONE and `cheese_visible` = 0 at t+1. `spawned` never fires again until `reset` followed by `game_start`.
- `jerrypos` is sampled combinationally during DRAW. It needs no synchronizer because it is on the same clock domain.

## Test plan
- Reset: hold `rst` low mid-WAIT. Required: `cheese_visible`/`spawned`/`busy` = 0 and `cheesepos` = (0,0) immediately; after release, state is IDLE.
- Start and pickup with `RESPAWN_DELAY`=4, Jerry at (0,0). Pulse `game_start` at cycle 10 → `spawned` at cycle 12 or later, with x in [32,760] and y ∈ {520,400,280,160}. Pulse taken at cycle 20 → visible = 0 at 21, next `spawned` at cycle ≥ 26.
- Jerry exclusion: place Jerry at a candidate position (force the LFSR seed so the first candidate overlaps Jerry). Required: that candidate is rejected, and the committed position is outside the clearance box or is the fallback (32,520).
- Fallback with `X_MAX` = `X_MIN`: almost every draw is out of range. Required: after exactly 8 attempts, `cheesepos` = (32,520) and `spawned` pulses once.
- Goal priority: pulse `cheese_gm` and `is_cheese_taken` in the same cycle while SHOWN → DONE. Hold 1000 cycles with no `spawned`; then pulse `reset` followed by `game_start` → a new spawn occurs.
- Ignored inputs: taken pulse in IDLE/WAIT/DONE, and `game_start` in SHOWN. Required: no state change. With `game_start` and `reset` high together, the block stays in IDLE.
